// File: rtl/branch_resolve_unit.sv
// Bimodal branch predictor: 2-bit PHT lookup at fetch, prediction carried
// through D and E, resolution and PHT training in execute.
module branch_resolve_unit #(
    parameter int INDEX_SIZE = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcF,
    input  logic        BTBHit,
    input  logic [31:0] branchimmF,
    input  logic        stallD,
    input  logic        stallE,
    input  logic        flushD,
    input  logic        flushE,
    input  logic        branchD,
    input  logic [31:0] branchimmD,
    input  logic        branchTakenE,
    output logic        predTakenF,
    output logic [31:0] predPcF,
    output logic        BTBWriteD,
    output logic        mispredictE,
    output logic [31:0] redirectPcE,
    output logic [31:0] branchCount,
    output logic [31:0] mispredCount
);
    localparam int NPHT = 1 << INDEX_SIZE;

    logic [1:0]            pht_q [NPHT];
    logic [1:0]            phtE_d;
    logic [INDEX_SIZE-1:0] idxF, idxE;
    logic                  updE;

    logic        validD_q, predTakenD_q, btbHitD_q;
    logic [31:0] pcD_q;
    logic        validE_q, branchE_q, predTakenE_q;
    logic [31:0] pcE_q, immE_q;
    logic [31:0] branchCount_q, mispredCount_q;

    assign idxF = pcF[INDEX_SIZE+1:2];
    assign idxE = pcE_q[INDEX_SIZE+1:2];

    // Fetch reads the registered PHT, so a same-cycle E update is seen next cycle.
    assign predTakenF = BTBHit & pht_q[idxF][1];
    assign predPcF    = pcF + (predTakenF ? branchimmF : 32'd4);

    assign BTBWriteD   = validD_q & branchD & ~btbHitD_q & ~stallD & ~flushD;
    assign updE        = validE_q & branchE_q & ~stallE;
    assign mispredictE = updE & (branchTakenE ^ predTakenE_q);
    assign redirectPcE = pcE_q + (branchTakenE ? immE_q : 32'd4);

    assign branchCount  = branchCount_q;
    assign mispredCount = mispredCount_q;

    always_comb begin
        phtE_d = pht_q[idxE];
        if (branchTakenE) begin
            if (phtE_d != 2'b11) phtE_d = phtE_d + 2'b01;
        end else if (phtE_d != 2'b00) begin
            phtE_d = phtE_d - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPHT; i++) pht_q[i] <= 2'b01;
        end else if (updE) begin
            pht_q[idxE] <= phtE_d;
        end
    end

    // F->D: flush beats stall; only valid/prediction need clearing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validD_q     <= 1'b0;
            predTakenD_q <= 1'b0;
            btbHitD_q    <= 1'b0;
            pcD_q        <= '0;
        end else if (flushD) begin
            validD_q     <= 1'b0;
            predTakenD_q <= 1'b0;
        end else if (!stallD) begin
            validD_q     <= 1'b1;
            predTakenD_q <= predTakenF;
            btbHitD_q    <= BTBHit;
            pcD_q        <= pcF;
        end
    end

    // D->E: a stalled decode feeds a bubble into execute.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validE_q     <= 1'b0;
            branchE_q    <= 1'b0;
            predTakenE_q <= 1'b0;
            pcE_q        <= '0;
            immE_q       <= '0;
        end else if (flushE) begin
            validE_q     <= 1'b0;
            branchE_q    <= 1'b0;
            predTakenE_q <= 1'b0;
            pcE_q        <= '0;
            immE_q       <= '0;
        end else if (!stallE) begin
            if (stallD) begin
                validE_q     <= 1'b0;
                branchE_q    <= 1'b0;
                predTakenE_q <= 1'b0;
            end else begin
                validE_q     <= validD_q;
                branchE_q    <= branchD;
                predTakenE_q <= predTakenD_q;
                pcE_q        <= pcD_q;
                immE_q       <= branchimmD;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branchCount_q  <= '0;
            mispredCount_q <= '0;
        end else begin
            if (updE)        branchCount_q  <= branchCount_q + 32'd1;
            if (mispredictE) mispredCount_q <= mispredCount_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized + directed bench for branch_resolve_unit against a behavioural
// pipeline/predictor model; outputs compared every negedge.
module tb_branch_resolve_unit;
    localparam int NPHT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pcF = '0, branchimmF = '0, branchimmD = '0;
    logic        BTBHit = 0, stallD = 0, stallE = 0, flushD = 0, flushE = 0;
    logic        branchD = 0, branchTakenE = 0;
    logic        predTakenF, BTBWriteD, mispredictE;
    logic [31:0] predPcF, redirectPcE, branchCount, mispredCount;

    branch_resolve_unit #(.INDEX_SIZE(6)) dut (
        .clk(clk), .reset(reset), .pcF(pcF), .BTBHit(BTBHit), .branchimmF(branchimmF),
        .stallD(stallD), .stallE(stallE), .flushD(flushD), .flushE(flushE),
        .branchD(branchD), .branchimmD(branchimmD), .branchTakenE(branchTakenE),
        .predTakenF(predTakenF), .predPcF(predPcF), .BTBWriteD(BTBWriteD),
        .mispredictE(mispredictE), .redirectPcE(redirectPcE),
        .branchCount(branchCount), .mispredCount(mispredCount)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", n, act, exp, $time);
        end
    endtask

    // Behavioural model: counter table plus the instruction held in each stage.
    int unsigned pht_m [NPHT];
    bit          mdv, mdpt, mdbh;
    logic [31:0] mdpc;
    bit          mev, mebr, mept;
    logic [31:0] mepc, meimm;
    logic [31:0] bc_m, mc_m;

    function automatic int ix(input logic [31:0] pc);
        return int'((pc >> 2) % NPHT);
    endfunction
    function automatic bit m_predT();
        return BTBHit && (pht_m[ix(pcF)] >= 2);
    endfunction
    function automatic bit m_upd();
        return mev && mebr && !stallE;
    endfunction
    function automatic bit m_mis();
        return m_upd() && (branchTakenE != mept);
    endfunction
    function automatic int unsigned sat(input int unsigned p, input bit t);
        if (t) return (p == 3) ? 3 : p + 1;
        return (p == 0) ? 0 : p - 1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            foreach (pht_m[i]) pht_m[i] <= 1;
            mdv <= 0; mdpt <= 0; mev <= 0; mebr <= 0; mept <= 0;
            bc_m <= 0; mc_m <= 0;
        end else begin
            if (m_upd()) begin
                pht_m[ix(mepc)] <= sat(pht_m[ix(mepc)], branchTakenE);
                bc_m <= bc_m + 1;
            end
            if (m_mis()) mc_m <= mc_m + 1;
            if (flushE) begin
                mev <= 0; mebr <= 0; mept <= 0;
            end else if (!stallE) begin
                if (stallD) mev <= 0;
                else begin
                    mev <= mdv; mebr <= branchD; mept <= mdpt; mepc <= mdpc; meimm <= branchimmD;
                end
            end
            if (flushD) begin
                mdv <= 0; mdpt <= 0;
            end else if (!stallD) begin
                mdv <= 1; mdpt <= m_predT(); mdbh <= BTBHit; mdpc <= pcF;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk1("predTakenF", predTakenF, m_predT());
            chk("predPcF", predPcF, m_predT() ? pcF + branchimmF : pcF + 32'd4);
            chk1("BTBWriteD", BTBWriteD, mdv && branchD && !mdbh && !stallD && !flushD);
            chk1("mispredictE", mispredictE, m_mis());
            if (m_mis())
                chk("redirectPcE", redirectPcE, branchTakenE ? mepc + meimm : mepc + 32'd4);
            chk("branchCount", branchCount, bc_m);
            chk("mispredCount", mispredCount, mc_m);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clean();
        branchD = 0; flushD = 1; flushE = 1;
        step();
        flushD = 0; flushE = 0;
    endtask

    logic [31:0] mcs;

    initial begin
        pcF = 32'h100; BTBHit = 1; branchimmF = 32'h40;
        step();
        chk_on = 1;
        #1;
        chk1("rst_predTakenF", predTakenF, 1'b0);
        chk("rst_predPcF", predPcF, 32'h104);
        chk1("rst_BTBWriteD", BTBWriteD, 1'b0);
        chk1("rst_mispredictE", mispredictE, 1'b0);
        chk("rst_branchCount", branchCount, 32'd0);
        step();
        reset = 1;
        #1;
        chk1("init_predTakenF", predTakenF, 1'b0);
        chk("init_predPcF", predPcF, 32'h104);

        // Branch at 0x100 trained taken twice.
        branchD = 1; branchimmD = 32'h40; branchTakenE = 1;
        repeat (4) step();
        chk("train_pht", pht_m[0], 32'd3);
        chk1("train_predTakenF", predTakenF, 1'b1);
        chk("train_predPcF", predPcF, 32'h140);
        clean();

        // Predicted-taken branch at 0x200 resolves not-taken; stallE blocks it.
        pcF = 32'h200; BTBHit = 1; branchimmF = 32'h10;
        step();
        branchD = 1; branchimmD = 32'h80; pcF = 32'h300; BTBHit = 0;
        step();
        branchD = 0; branchTakenE = 0; mcs = mc_m;
        #1;
        chk1("mis_flag", mispredictE, 1'b1);
        chk("mis_redirect", redirectPcE, 32'h204);
        stallE = 1;
        #1;
        chk1("mis_stalled", mispredictE, 1'b0);
        step();
        chk("mis_stall_cnt", mc_m, mcs);
        chk("mis_stall_pht", pht_m[0], 32'd3);
        stallE = 0;
        #1;
        chk1("mis_flag2", mispredictE, 1'b1);
        step();
        #1;
        chk("mis_count", mispredCount, mcs + 32'd1);
        chk("mis_pht", pht_m[0], 32'd2);
        clean();

        // Same-index read during a not-taken update from 2, then saturate at 0.
        pcF = 32'h200; BTBHit = 0;
        step();
        branchD = 1;
        step();
        branchD = 0; pcF = 32'h100; BTBHit = 1; branchimmF = 32'h40; branchTakenE = 0;
        #1;
        chk1("bypass_old", predTakenF, 1'b1);
        step();
        #1;
        chk1("bypass_new", predTakenF, 1'b0);
        branchD = 1;
        repeat (5) step();
        chk("sat_pht", pht_m[0], 32'd0);
        chk1("sat_predTakenF", predTakenF, 1'b0);
        clean();

        // BTB allocate held off by stallD, then a single pulse.
        pcF = 32'h400; BTBHit = 0;
        step();
        branchD = 1; stallD = 1;
        #1;
        chk1("btbw_stall0", BTBWriteD, 1'b0);
        step(); #1;
        chk1("btbw_stall1", BTBWriteD, 1'b0);
        step(); #1;
        chk1("btbw_stall2", BTBWriteD, 1'b0);
        stallD = 0; pcF = 32'h500; BTBHit = 1;
        #1;
        chk1("btbw_pulse", BTBWriteD, 1'b1);
        step(); #1;
        chk1("btbw_after", BTBWriteD, 1'b0);
        clean();

        // Reset with branches in D and E discards them.
        pcF = 32'h600; BTBHit = 0; branchD = 1; branchTakenE = 1;
        step(); step();
        chk1("rst2_bc_nonzero", branchCount != 0, 1'b1);
        pcF = 32'h100; BTBHit = 1; branchimmF = 32'h40;
        #1;
        reset = 0;
        #1;
        chk1("rst2_BTBWriteD", BTBWriteD, 1'b0);
        chk1("rst2_mispredictE", mispredictE, 1'b0);
        chk("rst2_branchCount", branchCount, 32'd0);
        chk("rst2_mispredCount", mispredCount, 32'd0);
        chk1("rst2_predTakenF", predTakenF, 1'b0);
        chk("rst2_predPcF", predPcF, 32'h104);
        step();
        reset = 1; branchD = 0;
        #1;
        chk1("rst2_post_pred", predTakenF, 1'b0);

        // Random traffic with PC aliasing across the table.
        for (int c = 0; c < 3000; c++) begin
            step();
            pcF          = 32'($urandom_range(0, 255)) << 2;
            BTBHit       = ($urandom_range(0, 3) != 0);
            branchimmF   = $urandom;
            branchD      = $urandom_range(0, 1) == 1;
            branchimmD   = $urandom;
            branchTakenE = $urandom_range(0, 1) == 1;
            stallD       = $urandom_range(0, 99) < 15;
            stallE       = $urandom_range(0, 99) < 10;
            flushD       = $urandom_range(0, 99) < 5;
            flushE       = $urandom_range(0, 99) < 5;
            if (c == 1500) begin
                #2 reset = 0;
                step(); step();
                reset = 1;
            end
        end
        step();
        chk_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
